// File: rtl/cal_seq.sv
// cal_seq: sequencer computing sum(1..N), one accumulate step per N_COMPUTE clocks.
// Optional define CAL_SEQ_SATURATE_EN clamps the sum to all-ones on carry.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : level run request, rising edge launches a run
//   n_in        : upper bound N, sampled on launch
//   acc_clr     : one-cycle accumulator clear pulse
//   acc_en      : one-cycle accumulate pulse per step
//   operand     : index added on acc_en, held between steps
//   sum_value   : registered running/final sum
//   busy, done  : run status
//   overflow    : sticky carry-out of the current run
module cal_seq #(
    parameter int BITWIDTH  = 8,
    parameter int N_COMPUTE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BITWIDTH-1:0] n_in,
    output logic                acc_clr,
    output logic                acc_en,
    output logic [BITWIDTH-1:0] operand,
    output logic [BITWIDTH-1:0] sum_value,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int PW       = $clog2(N_COMPUTE + 1);
    localparam int PRE_LAST = (N_COMPUTE > 1) ? N_COMPUTE - 2 : 0;
    localparam bit ONE_CLK  = (N_COMPUTE == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_STEP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_start_d;
    logic [BITWIDTH-1:0] r_n;
    logic [BITWIDTH-1:0] r_i;
    logic [BITWIDTH-1:0] r_op;
    logic [BITWIDTH-1:0] r_sum;
    logic                r_ovf;
    logic [PW-1:0]       r_pre;
    logic                w_launch;
    logic                w_pre_end;
    logic [BITWIDTH:0]   w_add;
    logic                w_clr;
    logic                w_en;
    logic                w_busy;
    logic                w_done;

    assign w_launch  = start & ~r_start_d;
    assign w_pre_end = (r_pre == PW'(PRE_LAST));
    assign w_add     = {1'b0, r_sum} + {1'b0, r_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_en   = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_launch) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                w_clr  = 1'b1;
                w_busy = 1'b1;
                if (!start)              w_next = S_IDLE;
                else if (r_n == '0)      w_next = S_DONE;
                else if (ONE_CLK)        w_next = S_STEP;
                else                     w_next = S_WAIT;
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (!start)              w_next = S_IDLE;
                else if (w_pre_end)      w_next = S_STEP;
            end
            S_STEP: begin
                w_en   = 1'b1;
                w_busy = 1'b1;
                if (!start)              w_next = S_IDLE;
                else if (r_i == r_n)     w_next = S_DONE;
                else if (ONE_CLK)        w_next = S_STEP;
                else                     w_next = S_WAIT;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (!start) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // An aborting STEP still commits its add, since acc_en is already out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d <= 1'b0;
            r_n       <= '0;
            r_i       <= '0;
            r_op      <= '0;
            r_sum     <= '0;
            r_ovf     <= 1'b0;
            r_pre     <= '0;
        end else begin
            r_start_d <= start;
            unique case (r_state)
                S_IDLE: begin
                    if (w_launch) r_n <= n_in;
                end
                S_CLEAR: begin
                    r_sum <= '0;
                    r_ovf <= 1'b0;
                    r_i   <= BITWIDTH'(1);
                    r_pre <= '0;
                end
                S_WAIT: begin
                    r_pre <= w_pre_end ? '0 : r_pre + PW'(1);
                end
                S_STEP: begin
                    r_op  <= r_i;
                    r_i   <= r_i + BITWIDTH'(1);
                    r_ovf <= r_ovf | w_add[BITWIDTH];
                    r_pre <= '0;
`ifdef CAL_SEQ_SATURATE_EN
                    // Once clamped, every later add carries, so it stays clamped.
                    r_sum <= w_add[BITWIDTH] ? '1 : w_add[BITWIDTH-1:0];
`else
                    r_sum <= w_add[BITWIDTH-1:0];
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign acc_clr   = w_clr;
    assign acc_en    = w_en;
    assign busy      = w_busy;
    assign done      = w_done;
    assign operand   = (r_state == S_STEP) ? r_i : r_op;
    assign sum_value = r_sum;
    assign overflow  = r_ovf;

endmodule

// File: doc/cal_seq.md
Name: cal_seq

Overview:
Sequencing controller for the summation datapath behind the board calculator. It computes sum(1..N) for a switch-supplied N, issuing one accumulate step every N_COMPUTE clocks. It owns the running accumulator and drives the clear/enable/operand controls, plus busy/done/overflow status for the LEDs. sum_value feeds the 7-segment display driver.

Parameters:
BITWIDTH, 8, width of N, operand and sum.
N_COMPUTE, 2, clocks per accumulate step (>=1).

Ports:
clk  input  1  system clock (CLK100MHZ domain)
rst_n  input  1  asynchronous active-low reset
start  input  1  level run request (SW[0]); rising edge launches a run
n_in  input  BITWIDTH  upper bound N; sampled on launch
acc_clr  output  1  one-cycle pulse; datapath clears accumulator
acc_en  output  1  one-cycle pulse per accumulate step
operand  output  BITWIDTH  value added on acc_en (current index i)
sum_value  output  BITWIDTH  registered running/final sum
busy  output  1  run in progress (CLEAR/WAIT/STEP)
done  output  1  result valid (LED[0])
overflow  output  1  sticky carry-out of any step in current run

Behaviour:
- Reset (async, rst_n=0): state IDLE; acc_clr=0, acc_en=0, operand=0, sum_value=0, busy=0, done=0, overflow=0; prescaler=0; start_d=0.
- Edge detect: launch = start & ~start_d, start_d registered each cycle. start_d resets to 0, so start held high through reset release launches exactly one run.
- IDLE: on launch, latch N=n_in -> CLEAR. Otherwise hold sum_value.
- CLEAR (1 cycle): acc_clr=1, sum<=0, overflow<=0, i<=1, busy=1. If N==0 -> DONE; else -> WAIT (or STEP if N_COMPUTE==1).
- WAIT: prescaler counts N_COMPUTE-1 cycles, then -> STEP.
- STEP (1 cycle): acc_en=1, operand=i; sum<=sum+i mod 2^BITWIDTH; overflow<=overflow|carry. If i==N -> DONE, else i<=i+1, -> WAIT.
- DONE: done=1, busy=0, sum_value/overflow held. Remains while start=1; start=0 -> IDLE, done<=0, sum_value retained.
- Latency: launch at cycle k -> done first high at k+2+N*N_COMPUTE (N>=1); k+2 for N==0.
- start falling while busy: abort to IDLE next cycle. done stays 0; partial sum_value and overflow retained.
- New launch is impossible while busy (start already high). Changes on n_in after launch are ignored.
- operand holds its last value outside STEP; acc_en and acc_clr are never high in the same cycle.
- i counter is BITWIDTH wide; N=2^BITWIDTH-1 terminates on the i==N compare with no wrap.

Optional Feature:
CAL_SEQ_SATURATE_EN: when defined, a step with carry clamps sum_value to all-ones and it stays there for the rest of the run. overflow is still set. When undefined, the sum wraps modulo 2^BITWIDTH.

Test Plan:
- Reset release with start=1, n_in=2, N_COMPUTE=2 -> acc_clr pulse at k+1, acc_en at k+3 (operand 1) and k+5 (operand 2), done=1 at k+6, sum_value=0x03, overflow=0.
- start rise, n_in=10 -> done after 22 cycles, sum_value=0x37, overflow=0. Drop start -> done=0 next cycle, sum_value stays 0x37.
- n_in=23 -> sum_value=0x14, overflow=1. With CAL_SEQ_SATURATE_EN -> sum_value=0xFF, overflow=1.
- n_in=0 -> CLEAR then DONE at k+2, sum_value=0, no acc_en pulse.
- Abort: n_in=10, drop start after 3rd acc_en -> IDLE, done=0, busy=0, sum_value=0x06. Re-raise start -> fresh run ends at 0x37.
- Assert rst_n=0 mid-run (during WAIT) -> all outputs 0 immediately. Release with start=1 -> new run launches.
